// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to the 8x16 register file and serves two bypassed read ports.
// Optional retired-write counter is enabled by defining WB_RETIRE_COUNT_EN.
module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        m3_in,
    input  logic              reg_write_in,
    input  logic [ADDR_W-1:0] wr_add_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] mem_rd_data_in,
    input  logic [DATA_W-1:0] shift_in,
    input  logic [DATA_W-1:0] pc_p1_in,
    input  logic              mem_rd_in,
    input  logic [ADDR_W-1:0] rd_add_a,
    input  logic [ADDR_W-1:0] rd_add_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_valid,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] pc_target,
    output logic              z_ld_out,
    output logic [15:0]       retire_cnt
);

    typedef enum logic [1:0] {
        SEL_ALU   = 2'b00,
        SEL_MEM   = 2'b01,
        SEL_SHIFT = 2'b10,
        SEL_PC_P1 = 2'b11
    } wb_sel_e;

    localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(NREG - 1);

    logic [DATA_W-1:0] regfile_q [NREG];
    logic              z_ld_q;
    logic              z_ld_d;

    always_comb begin
        wb_data = alu_res_in;
        case (wb_sel_e'(m3_in))
            SEL_ALU:   wb_data = alu_res_in;
            SEL_MEM:   wb_data = mem_rd_data_in;
            SEL_SHIFT: wb_data = shift_in;
            SEL_PC_P1: wb_data = pc_p1_in;
            default:   wb_data = alu_res_in;
        endcase
    end

    assign wb_valid    = reg_write_in;
    assign pc_redirect = reg_write_in & ~rst & (wr_add_in == PC_REG);
    assign pc_target   = wb_data;

    // Write-through: a reader of the register being written sees the new value in the same cycle.
    always_comb begin
        rd_data_a = regfile_q[rd_add_a];
        rd_data_b = regfile_q[rd_add_b];
        if (reg_write_in && (rd_add_a == wr_add_in)) rd_data_a = wb_data;
        if (reg_write_in && (rd_add_b == wr_add_in)) rd_data_b = wb_data;
    end

    // NOTE: the architectural registers must read zero after reset, so this storage is reset
    // explicitly; that keeps it in flops rather than a RAM macro, which is fine at 8x16.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regfile_q[i] <= '0;
        end else if (reg_write_in) begin
            regfile_q[wr_add_in] <= wb_data;
        end
    end

    // Load-zero flag only tracks loads that actually retire a register write.
    always_comb begin
        z_ld_d = z_ld_q;
        if (mem_rd_in && reg_write_in) z_ld_d = (mem_rd_data_in == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) z_ld_q <= 1'b0;
        else     z_ld_q <= z_ld_d;
    end

    assign z_ld_out = z_ld_q;

`ifdef WB_RETIRE_COUNT_EN
    logic [15:0] retire_cnt_q;
    logic [15:0] retire_cnt_d;

    // Saturating count of committed writes; it sticks at all-ones instead of wrapping.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (reg_write_in && (retire_cnt_q != 16'hFFFF)) retire_cnt_d = retire_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) retire_cnt_q <= 16'h0000;
        else     retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;
`else
    assign retire_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expected values are hand-computed constants.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m3_in;
    logic        reg_write_in;
    logic [2:0]  wr_add_in;
    logic [15:0] alu_res_in;
    logic [15:0] mem_rd_data_in;
    logic [15:0] shift_in;
    logic [15:0] pc_p1_in;
    logic        mem_rd_in;
    logic [2:0]  rd_add_a;
    logic [2:0]  rd_add_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic [15:0] wb_data;
    logic        wb_valid;
    logic        pc_redirect;
    logic [15:0] pc_target;
    logic        z_ld_out;
    logic [15:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk            (clk),
        .rst            (rst),
        .m3_in          (m3_in),
        .reg_write_in   (reg_write_in),
        .wr_add_in      (wr_add_in),
        .alu_res_in     (alu_res_in),
        .mem_rd_data_in (mem_rd_data_in),
        .shift_in       (shift_in),
        .pc_p1_in       (pc_p1_in),
        .mem_rd_in      (mem_rd_in),
        .rd_add_a       (rd_add_a),
        .rd_add_b       (rd_add_b),
        .rd_data_a      (rd_data_a),
        .rd_data_b      (rd_data_b),
        .wb_data        (wb_data),
        .wb_valid       (wb_valid),
        .pc_redirect    (pc_redirect),
        .pc_target      (pc_target),
        .z_ld_out       (z_ld_out),
        .retire_cnt     (retire_cnt)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one retiring instruction; outputs are sampled after the settle delay.
    task automatic drive(input logic we, input logic [2:0] wa, input logic [1:0] sel, input logic ld);
        reg_write_in = we;
        wr_add_in    = wa;
        m3_in        = sel;
        mem_rd_in    = ld;
        #1;
    endtask

    task automatic bubble();
        drive(1'b0, 3'd0, 2'b00, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        alu_res_in     = 16'hBEEF;
        mem_rd_data_in = 16'h0000;
        shift_in       = 16'h0000;
        pc_p1_in       = 16'h0000;
        rd_add_a       = 3'd3;
        rd_add_b       = 3'd3;
        drive(1'b1, 3'd3, 2'b00, 1'b0);
        tick();
        tick();
        drive(1'b1, 3'd7, 2'b00, 1'b0);
        check("redirect_in_reset", {15'd0, pc_redirect}, 16'h0000);
        tick();

        // Reset release: write of BEEF to R3 under reset must be discarded.
        rst = 1'b0;
        bubble();
        check("reset_r3", rd_data_a, 16'h0000);
        check("reset_zld", {15'd0, z_ld_out}, 16'h0000);
        check("reset_cnt", retire_cnt, 16'h0000);
        check("bubble_valid", {15'd0, wb_valid}, 16'h0000);

        // One write through each mux leg.
        alu_res_in = 16'h1234; drive(1'b1, 3'd1, 2'b00, 1'b0);
        check("mux_alu", wb_data, 16'h1234);
        check("valid_on_write", {15'd0, wb_valid}, 16'h0001);
        tick();
        mem_rd_data_in = 16'h00A5; drive(1'b1, 3'd2, 2'b01, 1'b0);
        check("mux_mem", wb_data, 16'h00A5);
        tick();
        shift_in = 16'h8000; drive(1'b1, 3'd4, 2'b10, 1'b0);
        check("mux_shift", wb_data, 16'h8000);
        tick();
        pc_p1_in = 16'h0042; drive(1'b1, 3'd5, 2'b11, 1'b0);
        check("mux_pc1", wb_data, 16'h0042);
        tick();
        bubble();
        rd_add_a = 3'd1; rd_add_b = 3'd2; #1;
        check("read_r1", rd_data_a, 16'h1234);
        check("read_r2", rd_data_b, 16'h00A5);
        rd_add_a = 3'd4; rd_add_b = 3'd5; #1;
        check("read_r4", rd_data_a, 16'h8000);
        check("read_r5", rd_data_b, 16'h0042);

        // Bypass on R6, first with the write disabled.
        rd_add_a = 3'd6; rd_add_b = 3'd6;
        alu_res_in = 16'h5A5A; drive(1'b0, 3'd6, 2'b00, 1'b0);
        check("nobyp_a", rd_data_a, 16'h0000);
        check("nobyp_b", rd_data_b, 16'h0000);
        drive(1'b1, 3'd6, 2'b00, 1'b0);
        check("byp_a", rd_data_a, 16'h5A5A);
        check("byp_b", rd_data_b, 16'h5A5A);
        rd_add_b = 3'd1; #1;
        check("byp_other_port", rd_data_b, 16'h1234);
        tick();
        bubble();
        check("r6_stored", rd_data_a, 16'h5A5A);

        // R7 write raises the redirect strobe only in its own cycle.
        alu_res_in = 16'h0100; drive(1'b1, 3'd7, 2'b00, 1'b0);
        check("redirect_hi", {15'd0, pc_redirect}, 16'h0001);
        check("pc_target", pc_target, 16'h0100);
        tick();
        bubble();
        rd_add_a = 3'd7; #1;
        check("r7_stored", rd_data_a, 16'h0100);
        check("redirect_lo", {15'd0, pc_redirect}, 16'h0000);
        alu_res_in = 16'h0777; drive(1'b1, 3'd6, 2'b00, 1'b0);
        check("redirect_other_reg", {15'd0, pc_redirect}, 16'h0000);
        tick();

        // Load-zero flag sequence; m3 deliberately not the memory leg on the second load.
        mem_rd_data_in = 16'h0000; drive(1'b1, 3'd2, 2'b01, 1'b1);
        tick();
        check("zld_set", {15'd0, z_ld_out}, 16'h0001);
        alu_res_in = 16'h0000; drive(1'b1, 3'd3, 2'b00, 1'b0);
        tick();
        check("zld_hold_nonload", {15'd0, z_ld_out}, 16'h0001);
        mem_rd_data_in = 16'h0001; drive(1'b0, 3'd3, 2'b01, 1'b1);
        tick();
        check("zld_hold_nowrite", {15'd0, z_ld_out}, 16'h0001);
        drive(1'b1, 3'd3, 2'b00, 1'b1);
        tick();
        check("zld_clear", {15'd0, z_ld_out}, 16'h0000);

        // Reset mid-stream discards the concurrent write; first post-reset write commits.
        rst = 1'b1;
        alu_res_in = 16'hFFFF; drive(1'b1, 3'd1, 2'b00, 1'b0);
        tick();
        rst = 1'b0;
        bubble();
        rd_add_a = 3'd1; rd_add_b = 3'd6; #1;
        check("midrst_r1", rd_data_a, 16'h0000);
        check("midrst_r6", rd_data_b, 16'h0000);
        check("midrst_cnt", retire_cnt, 16'h0000);
        alu_res_in = 16'hCAFE; drive(1'b1, 3'd1, 2'b00, 1'b0);
        tick();
        bubble();
        check("first_after_rst", rd_data_a, 16'hCAFE);

        // Counter: one write already done above, then 4 more interleaved with 3 bubbles.
        alu_res_in = 16'h0011;
        drive(1'b1, 3'd0, 2'b00, 1'b0); tick();
        bubble(); tick();
        drive(1'b1, 3'd0, 2'b00, 1'b0); tick();
        bubble(); tick();
        drive(1'b1, 3'd0, 2'b00, 1'b0); tick();
        bubble(); tick();
        drive(1'b1, 3'd0, 2'b00, 1'b0); tick();
        bubble();
`ifdef WB_RETIRE_COUNT_EN
        check("cnt_five", retire_cnt, 16'd5);
        @(negedge clk);
        dut.retire_cnt_q = 16'hFFFE;
        #1;
        drive(1'b1, 3'd0, 2'b00, 1'b0); tick();
        check("cnt_reach_max", retire_cnt, 16'hFFFF);
        drive(1'b1, 3'd0, 2'b00, 1'b0); tick();
        drive(1'b1, 3'd0, 2'b00, 1'b0); tick();
        check("cnt_saturate", retire_cnt, 16'hFFFF);
`else
        check("cnt_tied_zero", retire_cnt, 16'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
